patch_shuffler: RTL and testbench

PATCH_SHUFFLER -- requirements
Module: patch_shuffler

---
 rtl/patch_shuffler_pkg.sv | 29 ++
 rtl/lfsr16.sv | 17 +
 rtl/patch_shuffler.sv | 129 ++++++++++++
 tb/tb_patch_shuffler.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/patch_shuffler_pkg.sv
// Shared types, encodings and helpers for the patch shuffler.
package patch_shuffler_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    SLOT_EMPTY = 2'd0,
    SLOT_FULL  = 2'd1,
    SLOT_SENT  = 2'd2
  } slot_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, used for sizing indices and counters.
  function automatic int log2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, free-running out of reset.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [15:0] state
);

  localparam logic [15:0] TAPS = 16'hB400;

  always_ff @(posedge CLK) begin
    if (RESET) state <= SEED;
    else       state <= {1'b0, state[15:1]} ^ (state[0] ? TAPS : 16'h0000);
  end

endmodule

// File: rtl/patch_shuffler.sv
// Accepts patches in order and re-emits them in a bounded pseudo-random
// (or ascending) order within a sliding window of SYNC_WINDOW slots.
module patch_shuffler
  import patch_shuffler_pkg::*;
#(
  parameter int          DELAY       = 1,
  parameter int          SYNC_WINDOW = 8,
  parameter int          FP_SIZE     = 32,
  parameter int          N_PATCH     = 32,
  parameter int          SHUFFLE     = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       in_val,
  input  logic [FP_SIZE-1:0]         in_wtsum,
  output logic                       in_ack,
  input  logic                       patch_ack,
  output logic                       patch_val,
  output logic [log2(N_PATCH)-1:0]   patch_num,
  output logic [FP_SIZE-1:0]         wtsum,
  output logic                       done
);

  localparam int LW = log2(SYNC_WINDOW);
  localparam int PW = log2(N_PATCH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LAST = CW'(N_PATCH);

  if (DELAY < 0 || SYNC_WINDOW < 2 || SYNC_WINDOW > 64 || (1 << LW) != SYNC_WINDOW ||
      (1 << PW) != N_PATCH || N_PATCH < SYNC_WINDOW || LFSR_SEED == 16'h0000) begin : g_bad_params
    $error("patch_shuffler: illegal parameter set");
  end

  state_t             state, state_nx;
  slot_t              slot_q [SYNC_WINDOW];
  logic [FP_SIZE-1:0] data_q [SYNC_WINDOW];
  logic [CW-1:0]      next_in, base;
  logic [15:0]        lfsr;
  logic               lfsr_unused;

  logic [LW-1:0]      in_idx, base_idx, cand, fall_idx, scan_idx;
  logic               any_full, accept, release_slot;
  logic               emit_p0;
  logic [LW-1:0]      pick_p0, offset_p0;
  logic [PW-1:0]      num_p0;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLK   (CLK),
    .RESET (RESET),
    .state (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:LW];
  assign in_idx      = next_in[LW-1:0];
  assign base_idx    = base[LW-1:0];
  assign cand        = (SHUFFLE != 0) ? lfsr[LW-1:0] : base_idx;

  // The base slot may still be SENT awaiting release, so the fallback is the
  // oldest FULL slot found walking forward from base.
  always_comb begin
    any_full = FALSE;
    fall_idx = base_idx;
    scan_idx = base_idx;
    for (int i = 0; i < SYNC_WINDOW; i++) begin
      scan_idx = base_idx + LW'(i);
      if (!any_full && slot_q[scan_idx] == SLOT_FULL) begin
        fall_idx = scan_idx;
        any_full = TRUE;
      end
    end
  end

  assign in_ack       = !RESET && (state == ST_RUN) && (next_in != LAST) &&
                        (slot_q[in_idx] == SLOT_EMPTY);
  assign accept       = in_val && in_ack;
  assign release_slot = (slot_q[base_idx] == SLOT_SENT);
  assign done         = (state == ST_DONE);

  // p0: emission decision; registered outputs form p1
  assign emit_p0   = patch_ack && any_full;
  assign pick_p0   = (slot_q[cand] == SLOT_FULL) ? cand : fall_idx;
  assign offset_p0 = pick_p0 - base_idx;
  assign num_p0    = PW'(base + CW'(offset_p0));

  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:   if (next_in == LAST) state_nx = ST_DRAIN;
      ST_DRAIN: if (base == LAST)    state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_DONE;
      default:  state_nx = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_RUN;
      next_in   <= '0;
      base      <= '0;
      patch_val <= FALSE;
      patch_num <= '0;
      wtsum     <= '0;
      for (int i = 0; i < SYNC_WINDOW; i++) slot_q[i] <= SLOT_EMPTY;
    end else begin
      state <= state_nx;
      // Accept, emit and release always touch slots in distinct states.
      if (accept) begin
        slot_q[in_idx] <= SLOT_FULL;
        next_in        <= next_in + CW'(1);
      end
      if (emit_p0) slot_q[pick_p0] <= SLOT_SENT;
      if (release_slot) begin
        slot_q[base_idx] <= SLOT_EMPTY;
        base             <= base + CW'(1);
      end
      patch_val <= emit_p0;
      if (emit_p0) begin
        patch_num <= num_p0;
        wtsum     <= data_q[pick_p0];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) data_q[in_idx] <= in_wtsum;
  end

endmodule

// File: tb/tb_patch_shuffler.sv
// Bench for patch_shuffler: one ascending-order and one shuffled instance
// checked against a window/occupancy model of the patch stream.
module tb_patch_shuffler;

  localparam int W  = 8;
  localparam int NP = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_o = 1'b1, val_o = 1'b0, ack_o = 1'b0;
  logic [31:0] wt_o = '0;
  logic        in_ack_o, pv_o, done_o;
  logic [4:0]  pn_o;
  logic [31:0] ws_o;

  logic        rst_s = 1'b1, val_s = 1'b0, ack_s = 1'b0;
  logic [31:0] wt_s = '0;
  logic        in_ack_s, pv_s, done_s;
  logic [4:0]  pn_s;
  logic [31:0] ws_s;

  patch_shuffler #(.SYNC_WINDOW(W), .N_PATCH(NP), .FP_SIZE(32), .SHUFFLE(0)) u_ord (
    .CLK(clk), .RESET(rst_o), .in_val(val_o), .in_wtsum(wt_o), .in_ack(in_ack_o),
    .patch_ack(ack_o), .patch_val(pv_o), .patch_num(pn_o), .wtsum(ws_o), .done(done_o)
  );

  patch_shuffler #(.SYNC_WINDOW(W), .N_PATCH(NP), .FP_SIZE(32), .SHUFFLE(1)) u_shf (
    .CLK(clk), .RESET(rst_s), .in_val(val_s), .in_wtsum(wt_s), .in_ack(in_ack_s),
    .patch_ack(ack_s), .patch_val(pv_s), .patch_num(pn_s), .wtsum(ws_s), .done(done_s)
  );

  int n_pass = 0, n_fail = 0, n_total = 0;
  bit sel;  // 0 = ordered instance under test, 1 = shuffled instance

  // Model: per-patch status 0 none, 1 held, 2 sent, 3 released
  int          st [NP];
  int          acc, base, mst, emit_cnt;
  logic        exp_pv;
  logic [4:0]  exp_pn;
  logic [31:0] exp_ws;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit any_held();
    for (int n = 0; n < NP; n++) if (st[n] == 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int lowest_held();
    for (int n = 0; n < NP; n++) if (st[n] == 1) return n;
    return -1;
  endfunction

  function automatic logic cur_done();
    return sel ? done_s : done_o;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < NP; n++) st[n] = 0;
    acc = 0; base = 0; mst = 0;
    exp_pn = '0; exp_ws = '0;
  endtask

  task automatic step(input bit r, input bit v, input bit a);
    int acc_pre, base_pre, pick;
    bit emit, rel, exp_ack;
    logic obs_pv, obs_done;
    logic [4:0] obs_pn;
    logic [31:0] obs_ws;
    if (!sel) begin
      rst_o = r; val_o = v; ack_o = a; wt_o = 1000 + acc;
      rst_s = 1'b1; val_s = 1'b0; ack_s = 1'b0;
    end else begin
      rst_s = r; val_s = v; ack_s = a; wt_s = 1000 + acc;
      rst_o = 1'b1; val_o = 1'b0; ack_o = 1'b0;
    end
    @(negedge clk);
    exp_ack = !r && mst == 0 && acc < NP && (acc - base) < W;
    chk("in_ack", 32'(sel ? in_ack_s : in_ack_o), 32'(exp_ack));
    acc_pre = acc; base_pre = base; emit = 1'b0;
    if (r) model_reset();
    else begin
      emit = a && any_held();
      rel  = base_pre < NP && st[base_pre] == 2;
      if (mst == 0 && acc_pre == NP) mst = 1;
      else if (mst == 1 && base_pre == NP) mst = 2;
      if (rel) begin st[base_pre] = 3; base++; end
      if (emit && !sel) begin
        pick = lowest_held();
        st[pick] = 2;
        exp_pn = 5'(pick);
        exp_ws = 1000 + pick;
      end
      if (exp_ack && v) begin st[acc] = 1; acc++; end
    end
    exp_pv = emit;
    @(posedge clk); #1;
    obs_pv   = sel ? pv_s : pv_o;
    obs_pn   = sel ? pn_s : pn_o;
    obs_ws   = sel ? ws_s : ws_o;
    obs_done = sel ? done_s : done_o;
    chk("patch_val", 32'(obs_pv), 32'(exp_pv));
    if (emit && sel) begin
      chk("shuf_window_held", 32'(int'(obs_pn) >= base_pre && int'(obs_pn) < base_pre + W &&
                                  int'(obs_pn) < acc_pre && st[obs_pn] == 1), 32'd1);
      if (st[obs_pn] == 1) st[obs_pn] = 2;
      exp_pn = obs_pn;
      exp_ws = 1000 + int'(obs_pn);
    end else begin
      chk("patch_num", 32'(obs_pn), 32'(exp_pn));
    end
    if (emit) emit_cnt++;
    chk("wtsum", obs_ws, exp_ws);
    chk("done", 32'(obs_done), 32'(mst == 2));
  endtask

  task automatic run_to_done(input int rate_val, input int rate_ack, input string tag);
    int guard;
    guard = 0;
    do begin
      step(1'b0, ($urandom % 100) < rate_val, ($urandom % 100) < rate_ack);
      guard++;
    end while (!cur_done() && guard < 600);
    chk(tag, 32'(cur_done()), 32'd1);
  endtask

  initial begin
    model_reset();
    emit_cnt = 0;

    // Ordered: reset values, in_ack low under reset
    sel = 1'b0;
    repeat (3) step(1'b1, 1'b1, 1'b1);
    // Full-rate stream, strict ascending order
    run_to_done(100, 100, "ord_full_done");
    repeat (4) step(1'b0, 1'b1, 1'b1);

    // Receiver stalled: window fills, then a single ack frees one slot
    step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    run_to_done(100, 100, "ord_stall_done");

    // Random handshakes
    step(1'b1, 1'b0, 1'b0);
    run_to_done(70, 60, "ord_rand_done");
    step(1'b1, 1'b0, 1'b0);
    run_to_done(40, 90, "ord_rand2_done");

    // Shuffled instance
    sel = 1'b1;
    repeat (2) step(1'b1, 1'b1, 1'b1);
    run_to_done(100, 100, "shf_full_done");
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    run_to_done(60, 50, "shf_rand_done");

    // Mid-run reset after five emissions, then a clean full run
    step(1'b1, 1'b0, 1'b0);
    emit_cnt = 0;
    for (int i = 0; i < 200 && emit_cnt < 5; i++) step(1'b0, 1'b1, ($urandom % 2) == 0);
    step(1'b1, 1'b1, 1'b1);
    run_to_done(100, 100, "shf_post_reset_done");
    repeat (3) step(1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
